// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: command codes, ALU op encodings and sequencer states for alu_op_sequencer
package alu_seq_pkg;
  localparam logic [2:0] CMD_ADD    = 3'b000;
  localparam logic [2:0] CMD_ABSDIF = 3'b001;
  localparam logic [2:0] CMD_SUB    = 3'b010;
  localparam logic [2:0] CMD_ADD2   = 3'b011;
  localparam logic [2:0] CMD_LOAD   = 3'b100;
  localparam logic [2:0] CMD_CLEAR  = 3'b101;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_ABSDIF = 2'b01;
  localparam logic [1:0] ALU_SUB    = 2'b10;
  localparam logic [1:0] ALU_ADD2   = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} seq_state_t;
endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: handshakes commands into an external 4-bit ALU, waits for settle, returns result
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_code,
  input  logic [3:0] cmd_operand,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [3:0] resp_data,
  output logic       resp_overflow,
  output logic       resp_zero,
  output logic       resp_err,
  output logic [3:0] acc
);
  seq_state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic accept, is_alu, is_ldclr;
  logic [3:0] ld_val;
  assign cmd_ready = state == S_IDLE;
  assign accept = cmd_valid & cmd_ready;
  assign is_alu = ~cmd_code[2];
  assign is_ldclr = cmd_code == CMD_LOAD || cmd_code == CMD_CLEAR;
  assign ld_val = cmd_code == CMD_LOAD ? cmd_operand : 4'd0;
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   state_next = accept ? (is_alu ? S_SETTLE : S_RESP) : S_IDLE;
      S_SETTLE: state_next = cnt == '0 ? S_RESP : S_SETTLE;
      S_RESP:   state_next = resp_ready ? S_IDLE : S_RESP;
      default:  state_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      acc <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_overflow <= 1'b0;
      resp_zero <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && is_alu) begin
        alu_a <= acc;
        alu_b <= cmd_operand;
        alu_op <= cmd_code[1:0];
        cnt <= CNT_W'(SETTLE_CYCLES - 1);
      end else if (accept) begin
        // LOAD/CLEAR and reserved codes answer at the accept edge without touching the ALU
        acc <= is_ldclr ? ld_val : acc;
        resp_data <= is_ldclr ? ld_val : acc;
        resp_zero <= is_ldclr && ld_val == 4'd0;
        resp_overflow <= 1'b0;
        resp_err <= ~is_ldclr;
        resp_valid <= 1'b1;
      end
      if (state == S_SETTLE && cnt != '0) cnt <= cnt - 1'b1;
      if (state == S_SETTLE && cnt == '0) begin
        acc <= alu_result;
        resp_data <= alu_result;
        resp_overflow <= alu_overflow;
        resp_zero <= alu_zero;
        resp_err <= 1'b0;
        resp_valid <= 1'b1;
      end
      if (state == S_RESP && resp_ready) resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of the sequencer driving a behavioural 4-bit ALU
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, resp_valid, resp_ready;
  logic resp_overflow, resp_zero, resp_err, alu_overflow, alu_zero;
  logic [2:0] cmd_code;
  logic [3:0] cmd_operand, alu_a, alu_b, alu_result, resp_data, acc;
  logic [1:0] alu_op;
  logic [3:0] sum, dif;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  alu_op_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_operand(cmd_operand), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_overflow(resp_overflow), .resp_zero(resp_zero),
    .resp_err(resp_err), .acc(acc)
  );
  // Reference ALU: 01 ABSDIF, 10 SUB, 00/11 ADD; overflow from operand/result signs
  always_comb begin
    sum = alu_a + alu_b;
    dif = alu_a - alu_b;
    alu_result = alu_op == 2'b01 ? (dif[3] ? 4'd0 - dif : dif) : alu_op == 2'b10 ? dif : sum;
    alu_overflow = alu_op[0] ^ alu_op[1] ? (alu_a[3] != alu_b[3]) && (dif[3] != alu_a[3])
                                         : (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
    alu_zero = alu_result == 4'd0;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [2:0] code, input logic [3:0] opnd);
    chk("ready_before_send", 8'(cmd_ready), 8'd1);
    cmd_valid = 1'b1;
    cmd_code = code;
    cmd_operand = opnd;
    step();
    cmd_valid = 1'b0;
    cmd_code = 3'b000;
    cmd_operand = 4'h0;
  endtask
  task automatic drain();
    chk("drain_valid", 8'(resp_valid), 8'd1);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("drain_cleared", 8'(resp_valid), 8'd0);
    chk("drain_ready", 8'(cmd_ready), 8'd1);
  endtask
  task automatic chk_resp(input string tag, input logic [3:0] d, input logic ov, input logic z, input logic e);
    chk({tag, "_valid"}, 8'(resp_valid), 8'd1);
    chk({tag, "_data"}, 8'(resp_data), 8'(d));
    chk({tag, "_ovf"}, 8'(resp_overflow), 8'(ov));
    chk({tag, "_zero"}, 8'(resp_zero), 8'(z));
    chk({tag, "_err"}, 8'(resp_err), 8'(e));
  endtask
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_code = 3'b000;
    cmd_operand = 4'h0;
    resp_ready = 1'b0;
    repeat (3) step();
    chk("rst_acc", 8'(acc), 8'd0);
    chk("rst_valid", 8'(resp_valid), 8'd0);
    chk("rst_alu", {alu_a, alu_b[1:0], alu_op}, 8'd0);
    rst = 1'b0;
    step();
    chk("rst_ready", 8'(cmd_ready), 8'd1);
    send(3'b100, 4'd5);
    chk_resp("load5", 4'd5, 1'b0, 1'b0, 1'b0);
    chk("load5_acc", 8'(acc), 8'd5);
    chk("load5_busy", 8'(cmd_ready), 8'd0);
    drain();
    send(3'b000, 4'd3);
    chk("add_alu_ab", {alu_a, alu_b}, 8'h53);
    chk("add_alu_op", 8'(alu_op), 8'd0);
    chk("add_k0_valid", 8'(resp_valid), 8'd0);
    step();
    chk("add_k1_valid", 8'(resp_valid), 8'd0);
    chk("add_k1_ab", {alu_a, alu_b}, 8'h53);
    step();
    chk_resp("add3", 4'd8, 1'b1, 1'b0, 1'b0);
    chk("add3_acc", 8'(acc), 8'd8);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = i[0];
      cmd_code = 3'b100;
      cmd_operand = 4'hF;
      step();
      chk_resp("hold", 4'd8, 1'b1, 1'b0, 1'b0);
      chk("hold_busy", 8'(cmd_ready), 8'd0);
      chk("hold_acc", 8'(acc), 8'd8);
    end
    cmd_valid = 1'b0;
    drain();
    chk("post_hold_acc", 8'(acc), 8'd8);
    send(3'b100, 4'd8);
    drain();
    send(3'b010, 4'd8);
    chk("sub_alu_op", 8'(alu_op), 8'd2);
    repeat (2) step();
    chk_resp("sub8", 4'd0, 1'b0, 1'b1, 1'b0);
    drain();
    send(3'b100, 4'd2);
    drain();
    send(3'b001, 4'd7);
    chk("absdif_alu_op", 8'(alu_op), 8'd1);
    repeat (2) step();
    chk("absdif_data", 8'(resp_data), 8'd5);
    chk("absdif_acc", 8'(acc), 8'd5);
    drain();
    send(3'b100, 4'd7);
    drain();
    send(3'b011, 4'd1);
    repeat (2) step();
    chk_resp("add2", 4'd8, 1'b1, 1'b0, 1'b0);
    drain();
    send(3'b100, 4'd3);
    drain();
    send(3'b000, 4'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_acc", 8'(acc), 8'd0);
    chk("abort_valid", 8'(resp_valid), 8'd0);
    chk("abort_ready", 8'(cmd_ready), 8'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_stale", 8'(resp_valid), 8'd0);
      chk("abort_acc_hold", 8'(acc), 8'd0);
    end
    send(3'b100, 4'd4);
    drain();
    send(3'b110, 4'd9);
    chk_resp("err110", 4'd4, 1'b0, 1'b0, 1'b1);
    chk("err110_acc", 8'(acc), 8'd4);
    drain();
    send(3'b111, 4'd1);
    chk_resp("err111", 4'd4, 1'b0, 1'b0, 1'b1);
    drain();
    send(3'b101, 4'd6);
    chk_resp("clear", 4'd0, 1'b0, 1'b1, 1'b0);
    chk("clear_acc", 8'(acc), 8'd0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
